// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// helpers that derive format constants from the exponent/fraction widths.
package fp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Bit positions inside the 4-bit flag word {invalid, overflow, underflow, inexact}
  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W  = 14,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point add/subtract with round-to-nearest-even,
// flush-to-zero, valid/ready handshake and per-result exception flags.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int W      = fp_width(EXP_W, MAN_W);
  localparam int SW     = MAN_W + 4;            // hidden + fraction + guard/round/sticky
  localparam int LW     = $clog2(SW + 1);
  localparam int XW     = EXP_W + LW + 2;       // signed headroom for exp+2 .. exp-SW
  localparam int STAGES = 4;
  localparam logic [EXP_W-1:0] EMAX = EXP_W'(exp_max(EXP_W));
  localparam logic [W-1:0]     QNAN = W'(canon_nan(EXP_W, MAN_W));

  // Special-case results are decided up front and ride alongside the datapath.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             special;
    logic [W-1:0]     spec_val;
    logic [3:0]       spec_flags;
  } side_t;

  typedef struct packed {
    side_t            side;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   sig_l;
    logic [MAN_W:0]   sig_s;
  } s1_t;

  typedef struct packed {
    side_t            side;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
  } s2_t;

  typedef struct packed {
    side_t            side;
    logic             sign;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [SW-1:0]    mant;
  } s3_t;

  logic [STAGES:1] vld_pipe;
  logic            stall, advance, in_fire;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  s3_t             s3_d, s3_q;
  logic [W-1:0]    res_sum;
  logic [3:0]      res_flags;

  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ~stall;
  assign in_fire   = in_valid & in_ready;

  // ---------------- S1: unpack, classify, order by magnitude ----------------
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)   return CLS_ZERO;
    if (e == EMAX) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic                   sa, sb, swap;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  fp_class_e              ca, cb;
  logic [MAN_W:0]         ma, mb;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;

  assign sa    = in_a[W-1];
  assign sb    = in_b[W-1] ^ in_op;
  assign ea    = in_a[W-2:MAN_W];
  assign eb    = in_b[W-2:MAN_W];
  assign fa    = in_a[MAN_W-1:0];
  assign fb    = in_b[MAN_W-1:0];
  assign ca    = classify(ea, fa);
  assign cb    = classify(eb, fb);
  assign ma    = (ca == CLS_ZERO) ? '0 : {1'b1, fa};
  assign mb    = (cb == CLS_ZERO) ? '0 : {1'b1, fb};
  assign mag_a = (ca == CLS_ZERO) ? '0 : {ea, fa};
  assign mag_b = (cb == CLS_ZERO) ? '0 : {eb, fb};
  assign swap  = mag_b > mag_a;

  always_comb begin
    s1_d          = '0;
    s1_d.side.tag = in_tag;
    s1_d.sign     = swap ? sb : sa;
    s1_d.sub      = sa ^ sb;
    s1_d.exp      = swap ? eb : ea;
    s1_d.diff     = swap ? (eb - ea) : (ea - eb);
    s1_d.sig_l    = swap ? mb : ma;
    s1_d.sig_s    = swap ? ma : mb;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      s1_d.side.special             = 1'b1;
      s1_d.side.spec_val            = QNAN;
      s1_d.side.spec_flags[FLG_INV] = 1'b1;
    end else if (ca == CLS_INF && cb == CLS_INF) begin
      s1_d.side.special = 1'b1;
      if (sa != sb) begin
        s1_d.side.spec_val            = QNAN;
        s1_d.side.spec_flags[FLG_INV] = 1'b1;
      end else begin
        s1_d.side.spec_val = {sa, EMAX, {MAN_W{1'b0}}};
      end
    end else if (ca == CLS_INF) begin
      s1_d.side.special  = 1'b1;
      s1_d.side.spec_val = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (cb == CLS_INF) begin
      s1_d.side.special  = 1'b1;
      s1_d.side.spec_val = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
      s1_d.side.special  = 1'b1;
      s1_d.side.spec_val = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // ---------------- S2: align smaller operand, add/subtract ----------------
  logic [SW-1:0]   ext_s, ext_l, aligned;
  logic [2*SW-1:0] sh_full;
  logic            collapse;

  assign ext_s    = {s1_q.sig_s, 3'b000};
  assign ext_l    = {s1_q.sig_l, 3'b000};
  assign sh_full  = {ext_s, {SW{1'b0}}} >> s1_q.diff;
  assign collapse = 32'(s1_q.diff) >= 32'(SW - 1);
  // Lower half of sh_full holds every bit shifted past the sticky position.
  assign aligned  = collapse ? SW'(|s1_q.sig_s)
                             : {sh_full[2*SW-1:SW+1], sh_full[SW] | (|sh_full[SW-1:0])};

  always_comb begin
    s2_d      = '0;
    s2_d.side = s1_q.side;
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp;
    s2_d.sum  = s1_q.sub ? ({1'b0, ext_l} - {1'b0, aligned})
                         : ({1'b0, ext_l} + {1'b0, aligned});
  end

  // ---------------- S3: normalise ----------------
  logic [LW-1:0] lz;

  fp_lzc #(.W(SW), .CW(LW)) u_lzc (
    .d   (s2_q.sum[SW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    s3_d      = '0;
    s3_d.side = s2_q.side;
    s3_d.sign = s2_q.sign;
    s3_d.zero = (s2_q.sum == '0);
    if (s2_q.sum[SW]) begin
      s3_d.mant = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
      s3_d.exp  = XW'(s2_q.exp) + XW'(1);
    end else begin
      s3_d.mant = s2_q.sum[SW-1:0] << lz;
      s3_d.exp  = XW'(s2_q.exp) - XW'(lz);
    end
  end

  // ---------------- S4: round, pack, flag ----------------
  logic                 rnd_up, inexact;
  logic [MAN_W+1:0]     rnd;
  logic signed [XW-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;

  assign inexact = |s3_q.mant[2:0];
  assign rnd_up  = s3_q.mant[2] & (s3_q.mant[1] | s3_q.mant[0] | s3_q.mant[3]);
  assign rnd     = {1'b0, s3_q.mant[SW-1:3]} + (MAN_W+2)'(rnd_up);
  assign exp_r   = $signed(s3_q.exp) + $signed(XW'(rnd[MAN_W+1]));
  assign frac_r  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

  always_comb begin
    res_sum   = '0;
    res_flags = '0;
    if (s3_q.side.special) begin
      res_sum   = s3_q.side.spec_val;
      res_flags = s3_q.side.spec_flags;
    end else if (s3_q.zero) begin
      res_sum = '0;
    end else if (exp_r >= $signed(XW'(EMAX))) begin
      res_sum            = {s3_q.sign, EMAX, {MAN_W{1'b0}}};
      res_flags[FLG_OVF] = 1'b1;
      res_flags[FLG_INX] = 1'b1;
    end else if (exp_r <= 0) begin
      res_sum            = {s3_q.sign, {(W-1){1'b0}}};
      res_flags[FLG_UNF] = 1'b1;
      res_flags[FLG_INX] = 1'b1;
    end else begin
      res_sum            = {s3_q.sign, exp_r[EXP_W-1:0], frac_r};
      res_flags[FLG_INX] = inexact;
    end
  end

  // A stall freezes every stage, so ordering and output stability come for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_sum   <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (advance) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_fire};
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      out_sum   <= res_sum;
      out_tag   <= s3_q.side.tag;
      out_flags <= res_flags;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed and randomized checks of fp_addsub_pipe (half precision) against an
// exact-integer reference model with explicit round-to-nearest-even.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_op, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag, out_flags;

  int checks = 0;
  int errors = 0;
  int dtag   = 0;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rst, input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic op, input logic [3:0] tag, input logic ordy);
    @(posedge clk); #1;
    reset = rst; in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag; out_ready = ordy;
    @(negedge clk);
  endtask

  // Exact value = signed integer * 2^-24, then rounded to 11 significant bits.
  function automatic logic [19:0] ref_fp(input logic [15:0] a, input logic [15:0] b, input logic op);
    logic   sa, sb, rs, za, zb, ia, ib, na, nb, up, inx;
    int     ea, eb, fa, fb, p, e, sh;
    longint va, vb, s, mag, q, rem, half;
    sa = a[15]; sb = b[15] ^ op;
    ea = int'(a[14:10]); eb = int'(b[14:10]); fa = int'(a[9:0]); fb = int'(b[9:0]);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31 && fa == 0); ib = (eb == 31 && fb == 0);
    na = (ea == 31 && fa != 0); nb = (eb == 31 && fb != 0);
    if (na || nb) return {4'b1000, 16'h7E00};
    if (ia && ib) return (sa != sb) ? {4'b1000, 16'h7E00} : {4'b0000, sa, 15'h7C00};
    if (ia) return {4'b0000, sa, 15'h7C00};
    if (ib) return {4'b0000, sb, 15'h7C00};
    if (za && zb) return {4'b0000, sa & sb, 15'h0000};
    va = za ? 64'sd0 : (longint'(1024 + fa) <<< (ea - 1));
    vb = zb ? 64'sd0 : (longint'(1024 + fb) <<< (eb - 1));
    s  = (sa ? -va : va) + (sb ? -vb : vb);
    if (s == 0) return 20'h0;
    rs  = (s < 0);
    mag = rs ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = p - 9;
    if (p > 10) begin
      sh   = p - 10;
      q    = mag >>> sh;
      rem  = mag - (q <<< sh);
      half = longint'(1) <<< (sh - 1);
      inx  = (rem != 0);
      up   = (rem > half) || (rem == half && q[0]);
    end else begin
      q = mag <<< (10 - p); inx = 1'b0; up = 1'b0;
    end
    q = q + longint'(up);
    if (q == 2048) begin q = 1024; e++; end
    if (e >= 31) return {4'b0101, rs, 15'h7C00};
    if (e <= 0)  return {4'b0011, rs, 15'h0000};
    return {3'b000, inx, rs, e[4:0], q[9:0]};
  endfunction

  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic [15:0] esum, input logic [3:0] eflg);
    logic [3:0] t;
    t = 4'(dtag);
    dtag++;
    cyc(0, 1, a, b, op, t, 1);
    chk({name, "_accept"}, in_ready, 1);
    for (int i = 1; i < 4; i++) cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    chk({name, "_early"}, out_valid, 0);
    cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_sum"}, out_sum, esum);
    chk({name, "_flags"}, out_flags, eflg);
    chk({name, "_tag"}, out_tag, t);
  endtask

  logic [23:0] sbq[$];
  logic [15:0] ra, rb;
  logic        rop, rv, rr;
  logic [3:0]  rt;
  int          idx, got, e;

  initial begin
    reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_tag = 0; out_ready = 1;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed arithmetic and boundary cases
    run_one("one_plus_one",   16'h3C00, 16'h3C00, 0, 16'h4000, 4'b0000);
    run_one("one_minus_one",  16'h3C00, 16'h3C00, 1, 16'h0000, 4'b0000);
    run_one("two_plus_negone",16'h4000, 16'hBC00, 0, 16'h3C00, 4'b0000);
    run_one("tie_to_even",    16'h3C00, 16'h1000, 0, 16'h3C00, 4'b0001);
    run_one("tie_round_up",   16'h3C01, 16'h1000, 0, 16'h3C02, 4'b0001);
    run_one("overflow",       16'h7BFF, 16'h7BFF, 0, 16'h7C00, 4'b0101);
    run_one("nan_in",         16'h7E00, 16'h3C00, 0, 16'h7E00, 4'b1000);
    run_one("inf_minus_inf",  16'h7C00, 16'hFC00, 0, 16'h7E00, 4'b1000);
    run_one("inf_plus_one",   16'h7C00, 16'h3C00, 1, 16'h7C00, 4'b0000);
    run_one("negzero_sum",    16'h8000, 16'h8000, 0, 16'h8000, 4'b0000);
    run_one("negzero_sub",    16'h8000, 16'h0000, 1, 16'h8000, 4'b0000);
    run_one("subnormal_flush",16'h0400, 16'h03FF, 0, 16'h0400, 4'b0000);
    run_one("underflow",      16'h0401, 16'h0400, 1, 16'h0000, 4'b0011);

    // Stall: six back-to-back ops, consumer not ready in cycles 5..8
    idx = 0; got = 0;
    for (int c = 0; c < 24; c++) begin
      cyc(0, idx < 6, 16'h3C00 + 16'(idx * 16'h0111), 16'h3800 + 16'(idx), 1'(idx & 1), 4'(idx),
          !(c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_tag", out_tag, 1);
        chk("stall_out_sum", out_sum, 32'(ref_fp(16'h3C00 + 16'h0111, 16'h3801, 1'b1) & 20'hFFFF));
      end
      if (out_valid && out_ready) begin
        chk("stall_order_tag", out_tag, got);
        chk("stall_result", {out_flags, out_sum},
            ref_fp(16'h3C00 + 16'(got * 16'h0111), 16'h3800 + 16'(got), 1'(got & 1)));
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("stall_accepted", idx, 6);
    chk("stall_delivered", got, 6);

    // Reset with three ops in flight
    for (int c = 0; c < 3; c++) cyc(0, 1, 16'h4000, 16'h3C00, 0, 4'(10 + c), 1);
    cyc(1, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    chk("midrst_out_valid", out_valid, 0);
    cyc(0, 1, 16'h4200, 16'h3C00, 1, 4'hD, 1);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
      chk("postrst_no_ghost", out_valid, 0);
    end
    cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_result", {out_tag, out_flags, out_sum}, {4'hD, 4'b0000, 16'h4000});

    // Randomized traffic with random back-pressure, scoreboarded against ref_fp
    for (int c = 0; c < 600; c++) begin
      ra  = 16'($urandom);
      rop = 1'($urandom);
      rt  = 4'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1, 2, 3: rb = 16'($urandom);
        default: begin
          e = int'(ra[14:10]) + int'($urandom_range(0, 4)) - 2;
          if (e < 0) e = 0;
          if (e > 31) e = 31;
          rb = {1'($urandom), 5'(e), 10'($urandom)};
        end
      endcase
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 3) != 0);
      cyc(0, rv, ra, rb, rop, rt, rr);
      chk("rnd_in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("rnd_unexpected_output", out_valid, 0);
        else chk("rnd_result", {out_tag, out_flags, out_sum}, sbq.pop_front());
      end
      if (in_valid && in_ready) sbq.push_back({rt, ref_fp(ra, rb, rop)});
    end
    for (int c = 0; c < 30 && sbq.size() != 0; c++) begin
      cyc(0, 0, 16'h0, 16'h0, 0, 4'h0, 1);
      if (out_valid && out_ready) chk("rnd_drain_result", {out_tag, out_flags, out_sum}, sbq.pop_front());
    end
    chk("rnd_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
